// File: rtl/rf_seq_ctrl.sv
// Register-file sequencer: fetches one instruction at a time, reads operands,
// runs the external ALU with a bounded wait, and writes the result back.
module rf_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic        read_Rp,
  output logic        read_Rq,
  output logic [3:0]  reg_num_Rp,
  output logic [3:0]  reg_num_Rq,
  output logic [3:0]  reg_num_wr,
  output logic        write,
  output logic [15:0] rf_in_value,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        halted,
  output logic        err_timeout,
  output logic [15:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [11:0] fields_q, fields_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [15:0] retire_q, retire_d;

  always_comb begin
    state_d    = state_q;
    fields_d   = fields_q;
    result_d   = result_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    retire_d   = retire_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          fields_d = instr[11:0];
          case (instr[15:12])
            4'h0: retire_d = retire_q + 16'd1;
            4'h1: begin
              result_d = {8'h00, instr[7:0]};
              state_d  = S_WB;
            end
            4'hF: begin
              retire_d = retire_q + 16'd1;
              state_d  = S_HALT;
            end
            default: state_d = S_READ;
          endcase
        end
      end
      S_READ:  state_d = S_ISSUE;
      S_ISSUE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A late alu_done still wins over the timeout on the final cycle.
        if (alu_done) begin
          result_d = alu_result;
          state_d  = S_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == TIMEOUT_CNT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WB: begin
        retire_d = retire_q + 16'd1;
        state_d  = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fields_q   <= 12'h000;
      result_q   <= 16'h0000;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      retire_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      fields_q   <= fields_d;
      result_q   <= result_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      retire_q   <= retire_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign read_Rp      = (state_q == S_READ);
  assign read_Rq      = (state_q == S_READ);
  assign alu_start    = (state_q == S_ISSUE);
  assign write        = (state_q == S_WB);
  assign halted       = (state_q == S_HALT);
  assign err_timeout  = err_q;
  assign retire_count = retire_q;
  assign reg_num_wr   = fields_q[11:8];
  assign reg_num_Rp   = fields_q[7:4];
  assign reg_num_Rq   = fields_q[3:0];
  assign rf_in_value  = result_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed bench for rf_seq_ctrl: a cycle-by-cycle vector table plus
// hand-written timeout, boundary and mid-operation reset sequences.
module tb_rf_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic        read_Rp, read_Rq;
  logic [3:0]  reg_num_Rp, reg_num_Rq, reg_num_wr;
  logic        write;
  logic [15:0] rf_in_value;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        halted;
  logic        err_timeout;
  logic [15:0] retire_count;

  int tests = 0;
  int fails = 0;

  rf_seq_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .read_Rp(read_Rp), .read_Rq(read_Rq),
    .reg_num_Rp(reg_num_Rp), .reg_num_Rq(reg_num_Rq), .reg_num_wr(reg_num_wr),
    .write(write), .rf_in_value(rf_in_value),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .halted(halted), .err_timeout(err_timeout), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] instr;
    logic        done;
    logic [15:0] res;
    logic [50:0] exp;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [50:0] e(input logic rdy, input logic rd, input logic st,
                                    input logic wr, input logic hlt, input logic err,
                                    input logic [3:0] rp, input logic [3:0] rq,
                                    input logic [3:0] wn, input logic [15:0] val,
                                    input logic [15:0] ret);
    return {rdy, rd, rd, st, wr, hlt, err, rp, rq, wn, val, ret};
  endfunction

  function automatic logic [50:0] actual();
    return {instr_ready, read_Rp, read_Rq, alu_start, write, halted, err_timeout,
            reg_num_Rp, reg_num_Rq, reg_num_wr, rf_in_value, retire_count};
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] ins,
                               input logic d, input logic [15:0] res);
    rst         = r;
    instr_valid = v;
    instr       = ins;
    alu_done    = d;
    alu_result  = res;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic saw_write;
  int   start_pulses;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)};
    vecs[1]  = '{1'b0, 1'b1, 16'h13A5, 1'b0, 16'h0000, e(0,0,0,1,0,0,4'hA,4'h5,4'h3,16'h00A5,16'd0)};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, e(1,0,0,0,0,0,4'hA,4'h5,4'h3,16'h00A5,16'd1)};
    vecs[3]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h00A5,16'd2)};
    vecs[4]  = '{1'b0, 1'b1, 16'h0456, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'h5,4'h6,4'h4,16'h00A5,16'd3)};
    vecs[5]  = '{1'b0, 1'b1, 16'h2712, 1'b1, 16'h5555, e(0,1,0,0,0,0,4'h1,4'h2,4'h7,16'h00A5,16'd3)};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h6666, e(0,0,1,0,0,0,4'h1,4'h2,4'h7,16'h00A5,16'd3)};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, e(0,0,0,0,0,0,4'h1,4'h2,4'h7,16'h00A5,16'd3)};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, e(0,0,0,1,0,0,4'h1,4'h2,4'h7,16'hBEEF,16'd3)};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'h1,4'h2,4'h7,16'hBEEF,16'd4)};
    vecs[10] = '{1'b0, 1'b1, 16'hF000, 1'b0, 16'h0000, e(0,0,0,0,1,0,4'h0,4'h0,4'h0,16'hBEEF,16'd5)};
    vecs[11] = '{1'b0, 1'b1, 16'h13A5, 1'b1, 16'h7777, e(0,0,0,0,1,0,4'h0,4'h0,4'h0,16'hBEEF,16'd5)};
    vecs[12] = '{1'b1, 1'b1, 16'h13A5, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)};
    vecs[13] = '{1'b0, 1'b1, 16'h1EFF, 1'b0, 16'h0000, e(0,0,0,1,0,0,4'hF,4'hF,4'hE,16'h00FF,16'd0)};
    vecs[14] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, e(1,0,0,0,0,0,4'hF,4'hF,4'hE,16'h00FF,16'd1)};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].instr, vecs[i].done, vecs[i].res);
      checkOutput($sformatf("vec%0d", i), {13'b0, actual()}, {13'b0, vecs[i].exp});
    end

    // Timeout: alu_done never arrives; abort after the 15th WAIT cycle.
    saw_write    = 1'b0;
    start_pulses = 0;
    applyStimulus(0, 1, 16'h3C45, 0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
      if (write) saw_write = 1'b1;
      if (alu_start) start_pulses++;
    end
    checkOutput("to_wait14", {13'b0, actual()}, {13'b0, e(0,0,0,0,0,0,4'h4,4'h5,4'hC,16'h00FF,16'd1)});
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    if (write) saw_write = 1'b1;
    checkOutput("to_abort", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,1,4'h4,4'h5,4'hC,16'h00FF,16'd1)});
    checkOutput("to_no_write", {63'b0, saw_write}, 64'd0);
    checkOutput("to_start_pulses", 64'(start_pulses), 64'd1);
    applyStimulus(0, 1, 16'h1201, 0, 16'h0000);
    checkOutput("sticky_err_wb", {13'b0, actual()}, {13'b0, e(0,0,0,1,0,1,4'h0,4'h1,4'h2,16'h0001,16'd1)});
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("sticky_err_idle", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,1,4'h0,4'h1,4'h2,16'h0001,16'd2)});

    // Boundary: alu_done on the very cycle the counter reaches TIMEOUT.
    applyStimulus(1, 0, 16'h0000, 0, 16'h0000);
    checkOutput("rst_clears_err", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)});
    applyStimulus(0, 1, 16'h4812, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 1, 16'hCAFE);
    checkOutput("edge_done_wb", {13'b0, actual()}, {13'b0, e(0,0,0,1,0,0,4'h1,4'h2,4'h8,16'hCAFE,16'd0)});
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("edge_done_idle", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h1,4'h2,4'h8,16'hCAFE,16'd1)});

    // Reset while in WAIT, with alu_done offered on the same edge.
    applyStimulus(0, 1, 16'h5321, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    applyStimulus(1, 0, 16'h0000, 1, 16'h1111);
    checkOutput("rst_wait", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)});
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("rst_wait_next", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)});

    // Reset at the edge ending READ: ISSUE must never be reached.
    applyStimulus(0, 1, 16'h6321, 0, 16'h0000);
    applyStimulus(1, 0, 16'h0000, 0, 16'h0000);
    checkOutput("rst_read", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)});

    // Reset during WB: the pending write is dropped.
    applyStimulus(0, 1, 16'h1777, 0, 16'h0000);
    checkOutput("wb_before_rst", {63'b0, write}, 64'd1);
    applyStimulus(1, 0, 16'h0000, 0, 16'h0000);
    checkOutput("rst_wb", {13'b0, actual()}, {13'b0, e(1,0,0,0,0,0,4'h0,4'h0,4'h0,16'h0000,16'd0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
